// File: rtl/clk_ratio_meter.sv
// Measures the period and high/low phase lengths of a divided clock in reference-clock
// cycles, flags a match against the expected ratio, and times out after 255 cycles.
module clk_ratio_meter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_ref_clk,
    input  logic       i_rst_n,
    input  logic       i_meas_en,
    input  logic       i_sig,
    input  logic [7:0] i_exp_ratio,
    output logic [7:0] o_ratio,
    output logic [7:0] o_high_cnt,
    output logic [7:0] o_low_cnt,
    output logic       o_valid,
    output logic       o_match,
    output logic       o_timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_dly_q;
    logic [7:0]             period_q, high_q;
    logic [7:0]             ratio_q, high_cnt_q, low_cnt_q;
    logic                   valid_q, match_q, timeout_q;

    logic       s_sig, rise, fall;
    logic [7:0] period_inc, high_inc, low_now, exp_half, exp_rest;
    logic       match_now;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q    <= '0;
            sig_dly_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_sig};
            sig_dly_q <= s_sig;
        end
    end

    assign s_sig = sync_q[SYNC_STAGES-1];
    assign rise  = s_sig & ~sig_dly_q;
    assign fall  = ~s_sig & sig_dly_q;

    // Counters saturate; the 255 timeout branch fires before they could ever wrap.
    assign period_inc = (period_q == 8'hFF) ? period_q : period_q + 8'd1;
    assign high_inc   = (s_sig && high_q != 8'hFF) ? high_q + 8'd1 : high_q;
    assign low_now    = period_q - high_q;
    assign exp_half   = i_exp_ratio >> 1;
    assign exp_rest   = i_exp_ratio - exp_half;
    assign match_now  = (period_q == i_exp_ratio) && (high_q == exp_half) && (low_now == exp_rest);

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            period_q   <= '0;
            high_q     <= '0;
            ratio_q    <= '0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            valid_q    <= 1'b0;
            match_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (!i_meas_en) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: state_q <= WAIT_RISE;
                    WAIT_RISE: begin
                        if (rise) begin
                            state_q  <= MEAS_HIGH;
                            period_q <= 8'd1;
                            high_q   <= 8'd1;
                        end
                    end
                    MEAS_HIGH, MEAS_LOW: begin
                        // A rise seen while still in MEAS_HIGH closes the period as well.
                        if (rise) begin
                            ratio_q    <= period_q;
                            high_cnt_q <= high_q;
                            low_cnt_q  <= low_now;
                            match_q    <= match_now;
                            valid_q    <= 1'b1;
                            state_q    <= MEAS_HIGH;
                            period_q   <= 8'd1;
                            high_q     <= 8'd1;
                        end else if (period_q == 8'hFF) begin
                            timeout_q <= 1'b1;
                            match_q   <= 1'b0;
                            state_q   <= WAIT_RISE;
                        end else begin
                            period_q <= period_inc;
                            if (state_q == MEAS_HIGH) begin
                                high_q <= high_inc;
                                if (fall) state_q <= MEAS_LOW;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_ratio    = ratio_q;
    assign o_high_cnt = high_cnt_q;
    assign o_low_cnt  = low_cnt_q;
    assign o_valid    = valid_q;
    assign o_match    = match_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench: a timestamp-based model predicts each result/timeout event from
// the driven edge times; a monitor pops and compares whenever the DUT reports one.
module tb_clk_ratio_meter;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n, en, sig;
    logic [7:0] exp_r;
    logic [7:0] o_ratio, o_high_cnt, o_low_cnt;
    logic       o_valid, o_match, o_timeout;

    always #5 clk = ~clk;

    clk_ratio_meter #(.SYNC_STAGES(S)) dut (
        .i_ref_clk(clk), .i_rst_n(rst_n), .i_meas_en(en), .i_sig(sig), .i_exp_ratio(exp_r),
        .o_ratio(o_ratio), .o_high_cnt(o_high_cnt), .o_low_cnt(o_low_cnt),
        .o_valid(o_valid), .o_match(o_match), .o_timeout(o_timeout)
    );

    typedef struct { bit tmo; int ratio; int high; int low; bit match; } ev_t;
    ev_t sb[$];

    int n_chk = 0, n_fail = 0;
    bit hist[$];
    bit en_v = 0, idle = 1, started = 0, rel_pending = 0;
    int exp_v = 0, cyc = 0, t_rise = 0, t_fall = 0;
    int last_r = 0, last_h = 0, last_l = 0;
    bit last_m = 0;

    function automatic void check(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // Reference model: period = time between sampled rises, high = fall - rise.
    // A value driven before edge k is seen as s_sig at edge k+S.
    function automatic void model_edge();
        int n;
        bit s, sp, rise, fall;
        ev_t e;
        n = hist.size();
        s = hist[n-1-S];
        sp = hist[n-2-S];
        rise = s & !sp;
        fall = !s & sp;
        cyc++;
        if (!en_v) begin
            idle = 1; started = 0;
        end else if (idle) begin
            idle = 0; started = 0;
        end else if (rise) begin
            if (started) begin
                e.tmo   = 0;
                e.ratio = cyc - t_rise;
                e.high  = t_fall - t_rise;
                e.low   = e.ratio - e.high;
                e.match = (e.ratio == exp_v) && (e.high == exp_v / 2) && (e.low == exp_v - exp_v / 2);
                sb.push_back(e);
                last_r = e.ratio; last_h = e.high; last_l = e.low; last_m = e.match;
            end
            started = 1; t_rise = cyc;
        end else if (started && (cyc - t_rise == 255)) begin
            e.tmo = 1; e.ratio = last_r; e.high = last_h; e.low = last_l; e.match = 0;
            sb.push_back(e);
            last_m = 0; started = 0;
        end
        if (fall) t_fall = cyc;
    endfunction

    task automatic step(input bit s);
        @(negedge clk);
        if (rel_pending) begin
            rel_pending = 0;
            rst_n = 1;
            hist.delete();
            repeat (S + 1) hist.push_back(1'b0);
            idle = 1; started = 0;
        end
        sig = s; en = en_v; exp_r = exp_v[7:0];
        hist.push_back(s);
        model_edge();
        if (hist.size() > S + 2) void'(hist.pop_front());
    endtask

    task automatic period(input int h, input int l);
        repeat (h) step(1'b1);
        repeat (l) step(1'b0);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_ratio"}, o_ratio, 0);
        check({tag, "_high"}, o_high_cnt, 0);
        check({tag, "_low"}, o_low_cnt, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_match"}, o_match, 0);
        check({tag, "_timeout"}, o_timeout, 0);
    endtask

    // Asserted mid-cycle so the asynchronous clear is observable before any edge.
    task automatic pulse_reset(input int hold);
        #3 rst_n = 0;
        sb.delete();
        last_r = 0; last_h = 0; last_l = 0; last_m = 0;
        #1 check_zero("reset_async");
        repeat (hold) @(posedge clk);
        rel_pending = 1;
    endtask

    initial begin : monitor
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && (o_valid || o_timeout)) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got v=%0d t=%0d ratio=%0d, expected no event",
                             o_valid, o_timeout, o_ratio);
                end else begin
                    e = sb.pop_front();
                    if (o_valid !== !e.tmo || o_timeout !== e.tmo || o_ratio != e.ratio[7:0] ||
                        o_high_cnt != e.high[7:0] || o_low_cnt != e.low[7:0] || o_match !== e.match) begin
                        n_fail++;
                        $display("FAIL result_event: got v=%0d t=%0d r=%0d h=%0d l=%0d m=%0d, expected v=%0d t=%0d r=%0d h=%0d l=%0d m=%0d",
                                 o_valid, o_timeout, o_ratio, o_high_cnt, o_low_cnt, o_match,
                                 !e.tmo, e.tmo, e.ratio, e.high, e.low, e.match);
                    end
                end
            end
        end
    end

    initial begin : stim
        int n, h, l, reps;
        rst_n = 1; en = 0; sig = 0; exp_r = 0;
        #1 rst_n = 0;
        #1 check_zero("reset_init");
        repeat (2) @(posedge clk);
        rel_pending = 1;

        en_v = 1; exp_v = 4;
        repeat (3) step(1'b0);
        repeat (6) period(2, 2);

        exp_v = 5;
        repeat (4) period(2, 3);
        exp_v = 6;
        repeat (3) period(2, 3);

        exp_v = 4;
        repeat (300) step(1'b1);
        repeat (3) step(1'b0);
        repeat (3) period(2, 2);

        repeat (2) period(2, 2);
        step(1'b1); step(1'b1); step(1'b0);
        en_v = 0;
        repeat (8) step(1'b0);
        check("hold_ratio", o_ratio, last_r);
        check("hold_high", o_high_cnt, last_h);
        check("hold_low", o_low_cnt, last_l);
        check("hold_match", o_match, last_m);

        en_v = 1; exp_v = 8;
        repeat (2) step(1'b0);
        repeat (2) period(4, 4);
        step(1'b1);
        repeat (S - 1) step(1'b1);
        en_v = 0;
        repeat (3) step(1'b1);
        repeat (4) step(1'b0);
        check("disable_wins_ratio", o_ratio, last_r);
        en_v = 1;
        repeat (3) period(4, 4);

        repeat (2) step(1'b1);
        pulse_reset(3);
        repeat (2) step(1'b0);
        repeat (3) period(4, 4);

        exp_v = 4;
        repeat (3) period(2, 2);
        repeat (2) period(3, 3);
        exp_v = 6;
        repeat (3) period(3, 3);

        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(2, 12);
            h = ($urandom_range(0, 1) == 1) ? n / 2 : $urandom_range(1, n - 1);
            l = n - h;
            exp_v = ($urandom_range(0, 1) == 1) ? n : $urandom_range(2, 12);
            reps = $urandom_range(2, 4);
            repeat (reps) period(h, l);
            if ($urandom_range(0, 7) == 0) begin
                en_v = 0;
                repeat ($urandom_range(1, 5)) step(1'b0);
                en_v = 1;
            end
        end

        repeat (S + 4) step(1'b0);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_ratio_meter.md
CLK_RATIO_METER -- requirements
Module: clk_ratio_meter

Interface
REQ-001 The block SHALL have one parameter: SYNC_STAGES, default 2, the number of synchronizer flops on i_sig (minimum 2).
REQ-002 The block SHALL have port i_ref_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_meas_en, input, 1 bit: enables measurement; low forces IDLE.
REQ-005 The block SHALL have port i_sig, input, 1 bit: the divided clock under measurement, asynchronous to i_ref_clk.
REQ-006 The block SHALL have port i_exp_ratio, input, 8 bits: the expected division ratio.
REQ-007 The block SHALL have port o_ratio, output, 8 bits: the last measured period in i_ref_clk cycles.
REQ-008 The block SHALL have port o_high_cnt, output, 8 bits: the last measured high-phase length.
REQ-009 The block SHALL have port o_low_cnt, output, 8 bits: the last measured low-phase length.
REQ-010 The block SHALL have port o_valid, output, 1 bit: a one-cycle pulse when new results are loaded.
REQ-011 The block SHALL have port o_match, output, 1 bit: a registered flag, true when the last result matches i_exp_ratio.
REQ-012 The block SHALL have port o_timeout, output, 1 bit: a one-cycle pulse when no closing edge arrives within 255 cycles.

Function
REQ-013 The block SHALL pass i_sig through SYNC_STAGES flops to form s_sig, and SHALL register s_sig once more to form s_sig_d.
REQ-014 The block SHALL decode edges as rise = s_sig & ~s_sig_d and fall = ~s_sig & s_sig_d.
REQ-015 The FSM SHALL have the states IDLE, WAIT_RISE, MEAS_HIGH and MEAS_LOW.
REQ-016 In IDLE with i_meas_en=1, the FSM SHALL go to WAIT_RISE on the next cycle.
REQ-017 In WAIT_RISE, on rise the FSM SHALL go to MEAS_HIGH, set period_cnt=1 and set high_cnt=1.
REQ-018 In MEAS_HIGH, each cycle the block SHALL increment period_cnt, and SHALL increment high_cnt while s_sig=1; on fall it SHALL go to MEAS_LOW.
REQ-019 In MEAS_LOW, each cycle the block SHALL increment period_cnt; on rise it SHALL load results and restart MEAS_HIGH with period_cnt=1 and high_cnt=1.
REQ-020 Result load SHALL set o_ratio=period_cnt, o_high_cnt=high_cnt, o_low_cnt=period_cnt-high_cnt and o_valid=1, all registered with o_valid asserted on the cycle after the rise cycle.
REQ-021 On result load, o_match SHALL be set to (period_cnt==i_exp_ratio) && (high_cnt==i_exp_ratio>>1) && (low==i_exp_ratio-(i_exp_ratio>>1)), with i_exp_ratio sampled at the load edge.
REQ-022 An odd ratio N SHALL therefore match only with high=(N-1)/2 and low=(N+1)/2.
REQ-023 If period_cnt reaches 255 in MEAS_HIGH or MEAS_LOW without the closing edge, the block SHALL pulse o_timeout for one cycle, clear o_match, go to WAIT_RISE, and leave o_ratio, o_high_cnt and o_low_cnt unchanged.
REQ-024 All counters SHALL be 8-bit and SHALL never wrap; 255 is terminal and triggers the timeout.
REQ-025 If rise occurs in MEAS_HIGH (glitch shorter than synchronizer resolution), the block SHALL treat it as the closing edge with low=period-high.
REQ-026 If i_meas_en goes low in any state, the FSM SHALL go to IDLE on the next edge, abandon the partial measurement without asserting o_valid or o_timeout, and hold its result outputs.
REQ-027 If i_meas_en goes low on the same cycle as a closing rise, disable SHALL win and no result SHALL load.
REQ-028 The first rise after enable SHALL only start a measurement; o_valid SHALL first assert after the second rise.

Reset
REQ-029 While i_rst_n=0, all synchronizer flops, s_sig_d, the counters, o_ratio, o_high_cnt, o_low_cnt, o_valid, o_match and o_timeout SHALL be 0, and the FSM SHALL be in IDLE.
REQ-030 Reset assertion SHALL take effect immediately, and reset release SHALL be observed at the next i_ref_clk edge.
REQ-031 Reset asserted mid-measurement SHALL discard the measurement; no o_valid or o_timeout pulse SHALL follow the reset.

Verification
REQ-032 i_sig = i_ref_clk/4 divided clock, i_exp_ratio=4 -> after the second rise, o_valid pulses with o_ratio=4, o_high_cnt=2, o_low_cnt=2 and o_match=1, then repeats every 4 cycles.
REQ-033 i_sig = /5 divided clock (high 2, low 3), i_exp_ratio=5 -> o_ratio=5, o_high_cnt=2, o_low_cnt=3, o_match=1; with i_exp_ratio=6, o_match=0.
REQ-034 i_sig held high after one rise -> o_timeout pulses once when period_cnt reaches 255, o_match=0 and the FSM is in WAIT_RISE; o_valid stays 0.
REQ-035 i_meas_en dropped in MEAS_LOW of the third period -> no further o_valid, and the outputs hold the second-period values.
REQ-036 i_rst_n pulsed low mid-period at ratio 8 -> all outputs are 0 immediately, and after release the first o_valid appears only after two rises.
REQ-037 Ratio switched from 4 to 6 on the fly -> one transitional result has o_match=0, then o_ratio=6 with o_match=1 once i_exp_ratio=6.
